reduct_pipe: RTL and testbench
==============================

Name: reduct_pipe

Overview:
- Pipelined, parametrised successor to the combinational N-input bitwise reduction tree.
- Reduces IN lanes of DATA bits to one DATA-bit word, using an operation chosen per transaction: and, or or xor, each with optional inversion.
- Adds a per-lane mask, configurable register insertion inside the tree, and valid/ready flow control, so it can sit in timing-critical datapaths such as the issue/commit logic and wide status aggregation.

Parameters:
- IN, 4: number of input lanes (>=1); tree is padded to EIN = 1<<$clog2(IN) leaves.
- DATA, 16: width of each lane and of the result.
- REG_INTV, 1: tree levels between pipeline registers (>=1).
- LOG2_IN (derived): $clog2(IN).
- LAT (derived): max(1, ceil(LOG2_IN/REG_INTV)); latency in cycles.

Ports:
- clk  in  1  clock
- reset_  in  1  reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  [IN-1:0][DATA-1:0]  lane data
- in_mask  in  IN  1 = lane participates; 0 = lane replaced by identity
- in_op  in  2  operation select: 0 = and, 1 = or, 2 = xor, 3 = reserved
- in_inv  in  1  invert result (nand/nor/xnor)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA  reduction result
- out_op  out  2  op of the presented result, for tagging/debug

Behaviour:
- One clock, clk. reset_ is asynchronous and active-low. It clears every stage valid bit and zeroes all stage data, op and inv registers, so out_valid=0, out_data=0 and out_op=0 during and after reset.
- Identity value: all ones for and; all zeros for or, xor and reserved.
- Masked lanes and padding leaves (index >= IN) take the identity value of the transaction's op.
- Op 3: out_data = {DATA{1'b0}} (before inversion); the transaction flows through normally.
- Inversion is applied once, at the final level, before the output register.
- Tree structure: binary tree with LOG2_IN levels.
  - A pipeline register follows every REG_INTV levels; the final register is always the output register.
  - IN=1 has no tree levels; it is a single register with the mask and inversion applied.
- Each register stage carries valid, data, op and inv, and advances independently.
  - Stage k loads when it is empty, or when stage k+1 takes its content (or, for the last stage, out_ready=1).
  - in_ready = stage-0 load enable. This collapses bubbles: a pipeline that is not full accepts input while out_ready=0.
- Latency: a transfer accepted at edge t appears with out_valid=1 after edge t+LAT-1, when not stalled.
- Throughput: 1 result per cycle when out_ready is held at 1.
- Output rules while out_valid=1 and out_ready=0:
  - out_data and out_op hold stable.
  - Upstream stages fill until all are full, then in_ready=0.
- Simultaneous out accept and in accept on a full pipe: the whole pipe shifts in the same cycle with no lost or duplicated entry.
- Ordering is strictly FIFO; there is no reordering.
- Reset asserted mid-transaction discards all in-flight entries immediately (asynchronous).
- in_data, in_mask, in_op and in_inv are sampled only when in_valid && in_ready.

Decomposition:
- Shared package reduct_pkg holds:
  - REDUCT_AND/OR/XOR/RSV op encodings (2-bit enum reduct_op_t);
  - function reduct_ident(op, width);
  - function reduct_f(op, a, b).
- Sub-module reduct_lvl: one combinational tree level plus an optional valid/data/op/inv register stage with its load-enable logic, parameterised by leaf count, DATA and REGISTERED.
- reduct_pipe instantiates reduct_lvl LOG2_IN times in a generate loop. REGISTERED is set every REG_INTV levels and on the last level.

Test Plan:
- IN=4, DATA=16, REG_INTV=1 (LAT=2), op=or, data {0x0001,0x0010,0x0100,0x1000}, mask=4'hF, out_ready=1 -> out_data=0x1111, out_valid 2 cycles after acceptance.
- IN=5, op=and, lanes all 0xFFFF except lane 4 = 0x00FF, mask=5'h0F -> 0xFFFF (lane 4 masked, padding = ones). Same with mask=5'h1F -> 0x00FF.
- IN=4, op=xor, inv=1, lanes {0xAAAA,0x5555,0x0F0F,0x0000}, mask=4'hF -> ~0xF0F0 = 0x0F0F; op=3 -> 0xFFFF (inverted zero).
- Back-to-back stream of 8 transactions with out_ready toggling 1,0,0,1,...:
  - results exact, in order, with no drop or duplicate;
  - out_data stable while stalled;
  - in_ready falls only when all LAT stages are full.
- IN=8, REG_INTV=2 (LAT=2) and IN=1 (LAT=1): latency matches LAT. IN=1 with mask=0, op=and -> 0xFFFF.
- Assert reset_=0 for 1 cycle with 2 entries in flight -> out_valid=0 and out_data=0 immediately. After release, the next accepted input emerges correctly after LAT cycles.

Source files
------------

// File: rtl/reduct_pkg.sv
// Shared op encodings and reduction helpers for the pipelined reduction tree.
// Helpers work on a wide vector; callers size-cast to their own DATA width.
package reduct_pkg;

  localparam int REDUCT_MAX_W = 256;

  typedef enum logic [1:0] {
    REDUCT_AND = 2'd0,
    REDUCT_OR  = 2'd1,
    REDUCT_XOR = 2'd2,
    REDUCT_RSV = 2'd3
  } reduct_op_t;

  // Neutral element of the op in the low 'width' bits: ones for and, zeros otherwise.
  function automatic logic [REDUCT_MAX_W-1:0] reduct_ident(input reduct_op_t op,
                                                           input int width);
    logic [REDUCT_MAX_W-1:0] r;
    r = '0;
    if (op == REDUCT_AND) r = {REDUCT_MAX_W{1'b1}} >> (REDUCT_MAX_W - width);
    return r;
  endfunction

  function automatic logic [REDUCT_MAX_W-1:0] reduct_f(input reduct_op_t op,
                                                       input logic [REDUCT_MAX_W-1:0] a,
                                                       input logic [REDUCT_MAX_W-1:0] b);
    logic [REDUCT_MAX_W-1:0] r;
    case (op)
      REDUCT_AND: r = a & b;
      REDUCT_OR:  r = a | b;
      REDUCT_XOR: r = a ^ b;
      default:    r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reduct_lvl.sv
// One level of the reduction tree, optionally followed by a flow-controlled
// register stage. LEAVES=1 is a pass-through level used for the single-lane case.
module reduct_lvl
  import reduct_pkg::*;
#(
  parameter int LEAVES     = 2,
  parameter int DATA       = 16,
  parameter bit REGISTERED = 1'b1,
  parameter bit LAST       = 1'b0,
  localparam int OUTS      = (LEAVES > 1) ? LEAVES / 2 : 1
) (
  input  logic                        clk,
  input  logic                        reset_,
  input  logic                        up_valid,
  output logic                        up_ready,
  input  logic [LEAVES-1:0][DATA-1:0] up_data,
  input  reduct_op_t                  up_op,
  input  logic                        up_inv,
  output logic                        dn_valid,
  input  logic                        dn_ready,
  output logic [OUTS-1:0][DATA-1:0]   dn_data,
  output reduct_op_t                  dn_op,
  output logic                        dn_inv
);

  logic [OUTS-1:0][DATA-1:0] red;
  logic [OUTS-1:0][DATA-1:0] lvl_out;

  if (LEAVES > 1) begin : g_red
    for (genvar j = 0; j < OUTS; j++) begin : g_pair
      assign red[j] = DATA'(reduct_f(up_op, REDUCT_MAX_W'(up_data[2*j]),
                                     REDUCT_MAX_W'(up_data[2*j+1])));
    end
  end else begin : g_single
    assign red[0] = up_data[0];
  end

  // Inversion happens exactly once, on the final level only.
  assign lvl_out = (LAST && up_inv) ? ~red : red;

  if (REGISTERED) begin : g_reg
    logic                      v_q;
    logic [OUTS-1:0][DATA-1:0] d_q;
    reduct_op_t                op_q;
    logic                      inv_q;
    logic                      load;

    // Load when empty or when the downstream side takes our content this cycle.
    assign load = !v_q || dn_ready;

    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
        v_q   <= 1'b0;
        d_q   <= '0;
        op_q  <= REDUCT_AND;
        inv_q <= 1'b0;
      end else if (load) begin
        v_q <= up_valid;
        if (up_valid) begin
          d_q   <= lvl_out;
          op_q  <= up_op;
          inv_q <= up_inv;
        end
      end
    end

    assign up_ready = load;
    assign dn_valid = v_q;
    assign dn_data  = d_q;
    assign dn_op    = op_q;
    assign dn_inv   = inv_q;
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = clk & reset_;
    assign up_ready   = dn_ready;
    assign dn_valid   = up_valid;
    assign dn_data    = lvl_out;
    assign dn_op      = up_op;
    assign dn_inv     = up_inv;
  end

endmodule

// File: rtl/reduct_pipe.sv
// Pipelined IN-lane bitwise reduction (and/or/xor with optional inversion),
// with per-lane mask, register insertion every REG_INTV levels and valid/ready.
module reduct_pipe
  import reduct_pkg::*;
#(
  parameter int IN       = 4,
  parameter int DATA     = 16,
  parameter int REG_INTV = 1
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN-1:0][DATA-1:0] in_data,
  input  logic [IN-1:0]           in_mask,
  input  logic [1:0]              in_op,
  input  logic                    in_inv,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA-1:0]         out_data,
  output logic [1:0]              out_op
);

  localparam int LOG2_IN = $clog2(IN);
  localparam int EIN     = 1 << LOG2_IN;
  localparam int NLVL    = (LOG2_IN == 0) ? 1 : LOG2_IN;

  // Handshake: a transfer happens on a clock edge where valid && ready on the
  // same side. Valid never depends on ready; ready may depend on downstream ready.

  reduct_op_t                op_sel;
  logic [DATA-1:0]           ident;
  logic [EIN-1:0][DATA-1:0]  leaves;

  assign op_sel = reduct_op_t'(in_op);
  assign ident  = DATA'(reduct_ident(op_sel, DATA));

  // Masked lanes, padding leaves and every lane of the reserved op become identity.
  for (genvar j = 0; j < EIN; j++) begin : g_leaf
    if (j < IN) begin : g_lane
      assign leaves[j] = (in_mask[j] && op_sel != REDUCT_RSV) ? in_data[j] : ident;
    end else begin : g_pad
      assign leaves[j] = ident;
    end
  end

  for (genvar i = 0; i < NLVL; i++) begin : g_lvl
    localparam int  LEAVES = EIN >> i;
    localparam int  OUTS   = (LEAVES > 1) ? LEAVES / 2 : 1;
    localparam bit  IS_LAST = (i == NLVL - 1);
    localparam bit  IS_REG  = (((i + 1) % REG_INTV) == 0) || IS_LAST;

    logic                        v_in;
    logic [LEAVES-1:0][DATA-1:0] d_in;
    reduct_op_t                  op_in;
    logic                        inv_in;
    logic                        rdy_dn;
    logic                        rdy_o;
    logic                        v_o;
    logic [OUTS-1:0][DATA-1:0]   d_o;
    reduct_op_t                  op_o;
    logic                        inv_o;

    if (i == 0) begin : g_src
      assign v_in   = in_valid;
      assign d_in   = leaves;
      assign op_in  = op_sel;
      assign inv_in = in_inv;
    end else begin : g_chain
      assign v_in   = g_lvl[i-1].v_o;
      assign d_in   = g_lvl[i-1].d_o;
      assign op_in  = g_lvl[i-1].op_o;
      assign inv_in = g_lvl[i-1].inv_o;
    end

    if (IS_LAST) begin : g_sink
      assign rdy_dn = out_ready;
    end else begin : g_next
      assign rdy_dn = g_lvl[i+1].rdy_o;
    end

    reduct_lvl #(
      .LEAVES    (LEAVES),
      .DATA      (DATA),
      .REGISTERED(IS_REG),
      .LAST      (IS_LAST)
    ) u_lvl (
      .clk     (clk),
      .reset_  (reset_),
      .up_valid(v_in),
      .up_ready(rdy_o),
      .up_data (d_in),
      .up_op   (op_in),
      .up_inv  (inv_in),
      .dn_valid(v_o),
      .dn_ready(rdy_dn),
      .dn_data (d_o),
      .dn_op   (op_o),
      .dn_inv  (inv_o)
    );
  end

  logic unused_inv;
  assign unused_inv = g_lvl[NLVL-1].inv_o;

  assign in_ready  = g_lvl[0].rdy_o;
  assign out_valid = g_lvl[NLVL-1].v_o;
  assign out_data  = g_lvl[NLVL-1].d_o[0];
  assign out_op    = g_lvl[NLVL-1].op_o;

endmodule

// File: tb/tb_reduct_pipe.sv
// Bench for reduct_pipe: four configurations share one stimulus stream and are
// checked by per-instance scoreboards against a flat lane-by-lane reference.
module tb_reduct_pipe;

  localparam int NDUT = 4;
  localparam int LAT_T [NDUT] = '{2, 3, 2, 1};
  localparam int NL_T  [NDUT] = '{4, 5, 8, 1};

  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  logic [7:0][15:0]  data;
  logic [7:0]        mask;
  logic [1:0]        op;
  logic              inv;
  logic              out_ready;
  logic [NDUT-1:0]   iv, rdy, ov, took;
  logic [15:0]       od [NDUT];
  logic [1:0]        oo [NDUT];

  logic [17:0] exp_q   [NDUT][$];
  int          acc_q   [NDUT][$];
  bit          exact_q [NDUT][$];

  int n_tests = 0, n_fail = 0, cyc = 0, mode = 0, pcnt = 0;
  logic [NDUT-1:0] prev_stall;
  logic [15:0]     prev_od [NDUT];
  logic [1:0]      prev_oo [NDUT];

  reduct_pipe #(.IN(4), .DATA(16), .REG_INTV(1)) dut4 (
    .clk(clk), .reset_(reset_), .in_valid(iv[0]), .in_ready(rdy[0]),
    .in_data(data[3:0]), .in_mask(mask[3:0]), .in_op(op), .in_inv(inv),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_op(oo[0]));

  reduct_pipe #(.IN(5), .DATA(16), .REG_INTV(1)) dut5 (
    .clk(clk), .reset_(reset_), .in_valid(iv[1]), .in_ready(rdy[1]),
    .in_data(data[4:0]), .in_mask(mask[4:0]), .in_op(op), .in_inv(inv),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_op(oo[1]));

  reduct_pipe #(.IN(8), .DATA(16), .REG_INTV(2)) dut8 (
    .clk(clk), .reset_(reset_), .in_valid(iv[2]), .in_ready(rdy[2]),
    .in_data(data[7:0]), .in_mask(mask[7:0]), .in_op(op), .in_inv(inv),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_op(oo[2]));

  reduct_pipe #(.IN(1), .DATA(16), .REG_INTV(1)) dut1 (
    .clk(clk), .reset_(reset_), .in_valid(iv[3]), .in_ready(rdy[3]),
    .in_data(data[0:0]), .in_mask(mask[0:0]), .in_op(op), .in_inv(inv),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .out_op(oo[3]));

  // Reference: fold the participating lanes one at a time from the identity.
  function automatic logic [17:0] model(input int n, input logic [7:0][15:0] d,
                                        input logic [7:0] m, input logic [1:0] o,
                                        input logic i);
    logic [15:0] acc;
    acc = (o == 2'd0) ? 16'hFFFF : 16'h0000;
    if (o != 2'd3) begin
      for (int j = 0; j < n; j++) begin
        if (m[j]) begin
          case (o)
            2'd0:    acc = acc & d[j];
            2'd1:    acc = acc | d[j];
            default: acc = acc ^ d[j];
          endcase
        end
      end
    end
    if (i) acc = ~acc;
    return {o, acc};
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, k, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (pcnt == 0);
        pcnt = (pcnt == 2) ? 0 : pcnt + 1;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: samples mid-cycle, checks ready/valid behaviour and pops results.
  always @(negedge clk) begin
    int lat;
    if (!reset_) begin
      took = '0;
      prev_stall = '0;
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        chk("in_ready", k, rdy[k], (exp_q[k].size() < LAT_T[k]) || out_ready);
        if (prev_stall[k]) begin
          chk("stall_valid", k, ov[k], 1);
          chk("stall_data", k, od[k], prev_od[k]);
          chk("stall_op", k, oo[k], prev_oo[k]);
        end
        if (ov[k]) begin
          if (exp_q[k].size() == 0) begin
            chk("spurious_valid", k, ov[k], 0);
          end else begin
            chk("data", k, od[k], exp_q[k][0][15:0]);
            chk("op", k, oo[k], exp_q[k][0][17:16]);
            if (out_ready) begin
              lat = cyc - acc_q[k][0];
              if (exact_q[k][0]) chk("latency", k, lat, LAT_T[k] - 1);
              else chk("latency_min", k, lat >= LAT_T[k] - 1, 1);
              void'(exp_q[k].pop_front());
              void'(acc_q[k].pop_front());
              void'(exact_q[k].pop_front());
            end
          end
        end
        prev_stall[k] = ov[k] && !out_ready;
        prev_od[k] = od[k];
        prev_oo[k] = oo[k];
        took[k] = iv[k] && rdy[k];
        if (took[k]) begin
          exp_q[k].push_back(model(NL_T[k], data, mask, op, inv));
          acc_q[k].push_back(cyc + 1);
          exact_q[k].push_back(mode == 0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that completed
  // the last outstanding acceptance, so successive calls stream back to back.
  task automatic send(input logic [7:0][15:0] d, input logic [7:0] m,
                      input logic [1:0] o, input logic i);
    data = d; mask = m; op = o; inv = i;
    iv = '1;
    for (int c = 0; c < 60 && iv != '0; c++) begin
      @(posedge clk);
      #1;
      iv = iv & ~took;
    end
    chk("accept", 0, iv, 0);
    iv = '0;
  endtask

  task automatic drain();
    for (int c = 0; c < 100; c++) begin
      if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0) break;
      idle(1);
    end
    for (int k = 0; k < NDUT; k++) chk("drain", k, exp_q[k].size(), 0);
  endtask

  task automatic send_rand(input int max_op);
    logic [7:0][15:0] d;
    for (int j = 0; j < 8; j++) d[j] = 16'($urandom);
    send(d, 8'($urandom_range(0, 255)), 2'($urandom_range(0, max_op)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][15:0] d;
    reset_ = 1'b1; iv = '0; data = '0; mask = '0; op = '0; inv = 1'b0; out_ready = 1'b1;
    #1 reset_ = 1'b0;
    #6;
    for (int k = 0; k < NDUT; k++) begin
      chk("reset_valid", k, ov[k], 0);
      chk("reset_data", k, od[k], 0);
      chk("reset_op", k, oo[k], 0);
    end
    repeat (2) @(posedge clk);
    #3 reset_ = 1'b1;
    idle(2);

    // Directed cases, consumer always ready.
    d = '0;
    d[0] = 16'h0001; d[1] = 16'h0010; d[2] = 16'h0100; d[3] = 16'h1000; d[4] = 16'h8000;
    send(d, 8'hFF, 2'd1, 1'b0);
    for (int j = 0; j < 8; j++) d[j] = 16'hFFFF;
    d[4] = 16'h00FF;
    send(d, 8'h0F, 2'd0, 1'b0);
    send(d, 8'h1F, 2'd0, 1'b0);
    d = '0;
    d[0] = 16'hAAAA; d[1] = 16'h5555; d[2] = 16'h0F0F; d[3] = 16'h0000;
    send(d, 8'hFF, 2'd2, 1'b1);
    send(d, 8'hFF, 2'd3, 1'b1);
    d[0] = 16'h1234;
    send(d, 8'h00, 2'd0, 1'b0);
    drain();

    // Stream of 8 with the consumer ready one cycle in three.
    mode = 1; pcnt = 0;
    idle(1);
    for (int t = 0; t < 8; t++) send_rand(2);
    drain();

    // Reset with entries in flight, then a clean transaction afterwards.
    mode = 0;
    idle(2);
    send_rand(3);
    send_rand(3);
    #2 reset_ = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("midreset_valid", k, ov[k], 0);
      chk("midreset_data", k, od[k], 0);
      exp_q[k].delete();
      acc_q[k].delete();
      exact_q[k].delete();
    end
    @(posedge clk);
    #3 reset_ = 1'b1;
    idle(1);
    send_rand(3);
    drain();

    // Random traffic with random backpressure.
    mode = 2;
    idle(1);
    for (int t = 0; t < 150; t++) send_rand(3);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
